// File: rtl/instr_pkg.sv
// instr_pkg: shared RV32I encoding constants and types.
// Holds the symbolic op enum, major opcodes and funct3/funct7 values used by
// the encoder; the decode side imports the same constants so both ends agree.
package instr_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpSub  = 3'd1,
        OpOr   = 3'd2,
        OpAnd  = 3'd3,
        OpLw   = 3'd4,
        OpSw   = 3'd5,
        OpBeq  = 3'd6,
        OpRsvd = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    localparam logic [6:0] OpcodeOp     = 7'b0110011;
    localparam logic [6:0] OpcodeLoad   = 7'b0000011;
    localparam logic [6:0] OpcodeStore  = 7'b0100011;
    localparam logic [6:0] OpcodeBranch = 7'b1100011;

    localparam logic [2:0] Funct3AddSub = 3'b000;
    localparam logic [2:0] Funct3Or     = 3'b110;
    localparam logic [2:0] Funct3And    = 3'b111;
    localparam logic [2:0] Funct3Word   = 3'b010;
    localparam logic [2:0] Funct3Beq    = 3'b000;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Sub  = 7'b0100000;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request handshake and instruction-memory write bus.
//   req_*   : symbolic operation request (valid/ready handshake)
//   imem_*  : one-word-per-cycle write port into instruction memory
// Modports: master = request source / memory sink, slave = encoder.
interface instr_encoder_if #(
    parameter int unsigned DEPTH = 64
);
    import instr_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              req_valid;
    logic              req_ready;
    op_e               req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [12:0]       req_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/rv_pack.sv
// rv_pack: combinational RV32I packer.
//   op, rd, rs1, rs2, imm in -> word (32-bit instruction), legal
// Fields an op does not use are ignored. Reserved op and odd BEQ offsets are
// flagged illegal; word content is don't-care in that case.
module rv_pack
    import instr_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        unique case (op)
            OpAdd:  word = {Funct7Base, rs2, rs1, Funct3AddSub, rd, OpcodeOp};
            OpSub:  word = {Funct7Sub, rs2, rs1, Funct3AddSub, rd, OpcodeOp};
            OpOr:   word = {Funct7Base, rs2, rs1, Funct3Or, rd, OpcodeOp};
            OpAnd:  word = {Funct7Base, rs2, rs1, Funct3And, rd, OpcodeOp};
            OpLw:   word = {imm[11:0], rs1, Funct3Word, rd, OpcodeLoad};
            OpSw:   word = {imm[11:5], rs2, rs1, Funct3Word, imm[4:0], OpcodeStore};
            OpBeq: begin
                // Branch offsets are 2-byte aligned; bit 0 is not encodable.
                word  = {imm[12], imm[10:5], rs2, rs1, Funct3Beq, imm[4:1], imm[11],
                         OpcodeBranch};
                legal = ~imm[0];
            end
            OpRsvd: legal = 1'b0;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential RV32I program loader.
//   clk, rst      : clock, asynchronous active-high reset
//   start, finish : session control pulses
//   bus (slave)   : request handshake in, instruction-memory write out
//   words         : words written this session
//   done          : high while in DONE
//   illegal       : one-cycle pulse per rejected request
//   err_count     : rejected requests this session, saturating at 255
module instr_encoder
    import instr_pkg::*;
#(
    parameter  int unsigned DEPTH  = 64,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    instr_encoder_if.slave        bus,
    output logic [ADDR_W:0]       words,
    output logic                  done,
    output logic                  illegal,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_W:0] PtrFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PtrLast = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              illegal_q;
    logic [7:0]        err_q;

    logic        accept;
    logic        accept_legal;
    logic        accept_illegal;
    logic        enter_load;
    logic [31:0] packed_word;
    logic        packed_legal;

    rv_pack u_pack (
        .op    (bus.req_op),
        .rd    (bus.req_rd),
        .rs1   (bus.req_rs1),
        .rs2   (bus.req_rs2),
        .imm   (bus.req_imm),
        .word  (packed_word),
        .legal (packed_legal)
    );

    // Ready depends only on registered state so it can never loop through valid.
    assign bus.req_ready   = (state_q == StLoad) && (ptr_q != PtrFull);
    assign accept          = bus.req_valid && bus.req_ready;
    assign accept_legal    = accept && packed_legal;
    assign accept_illegal  = accept && !packed_legal;

    always_comb begin
        state_d    = state_q;
        enter_load = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                // start takes priority over a coincident finish.
                if (start) begin
                    state_d    = StLoad;
                    enter_load = 1'b1;
                end
            end
            StLoad: begin
                // Leave on the cycle the last word is accepted; its write
                // still emits on the next cycle, alongside done.
                if (finish || (accept_legal && ptr_q == PtrLast)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= accept_legal;
            illegal_q <= accept_illegal;
            if (enter_load) begin
                ptr_q <= '0;
                err_q <= '0;
            end else begin
                if (accept_legal) begin
                    ptr_q   <= ptr_q + 1'b1;
                    addr_q  <= ptr_q[ADDR_W-1:0];
                    wdata_q <= packed_word;
                end
                if (accept_illegal && err_q != 8'hFF) begin
                    err_q <= err_q + 8'd1;
                end
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign words          = ptr_q;
    assign done           = (state_q == StDone);
    assign illegal        = illegal_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
// Two instances: DEPTH=64 for encoding/session behaviour, DEPTH=4 for fill.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_encoder;
    import instr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, finish_a = 1'b0;
    logic [6:0] words_a;
    logic       done_a, ill_a;
    logic [7:0] err_a;
    logic       start_b = 1'b0, finish_b = 1'b0;
    logic [2:0] words_b;
    logic       done_b, ill_b;
    logic [7:0] err_b;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder_if #(.DEPTH(64)) ia ();
    instr_encoder_if #(.DEPTH(4))  ib ();

    instr_encoder #(.DEPTH(64)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .finish(finish_a), .bus(ia),
        .words(words_a), .done(done_a), .illegal(ill_a), .err_count(err_a)
    );

    instr_encoder #(.DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .finish(finish_b), .bus(ib),
        .words(words_b), .done(done_b), .illegal(ill_b), .err_count(err_b)
    );

    task automatic drive_a(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [12:0] imm);
        ia.req_valid = 1'b1;
        ia.req_op    = op;
        ia.req_rd    = rd;
        ia.req_rs1   = rs1;
        ia.req_rs2   = rs2;
        ia.req_imm   = imm;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (ia.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b want 0", ia.req_ready); end
        n_checks++; if (ia.imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", ia.imem_we); end
        n_checks++; if (ia.imem_addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", ia.imem_addr); end
        n_checks++; if (ia.imem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", ia.imem_wdata); end
        n_checks++; if (words_a !== 7'd0) begin n_fail++; $display("FAIL rst_words: got %0d want 0", words_a); end
        n_checks++; if (done_a !== 1'b0 || ill_a !== 1'b0) begin n_fail++; $display("FAIL rst_done_ill: got %0b%0b want 00", done_a, ill_a); end
        n_checks++; if (err_a !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_a); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ia.req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %0b want 0", ia.req_ready); end
    endtask

    task automatic test_add();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n_checks++; if (ia.req_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %0b want 1", ia.req_ready); end
        drive_a(OpAdd, 5'd3, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        ia.req_valid = 1'b0;
        n_checks++; if (ia.imem_we !== 1'b1) begin n_fail++; $display("FAIL add_we: got %0b want 1", ia.imem_we); end
        n_checks++; if (ia.imem_addr !== 6'd0) begin n_fail++; $display("FAIL add_addr: got %0d want 0", ia.imem_addr); end
        n_checks++; if (ia.imem_wdata !== 32'h002081B3) begin n_fail++; $display("FAIL add_wdata: got %h want 002081b3", ia.imem_wdata); end
        n_checks++; if (words_a !== 7'd1) begin n_fail++; $display("FAIL add_words: got %0d want 1", words_a); end
        finish_a = 1'b1;
        @(negedge clk);
        finish_a = 1'b0;
        n_checks++; if (done_a !== 1'b1 || ia.imem_we !== 1'b0) begin n_fail++; $display("FAIL add_finish: done=%0b we=%0b want 1 0", done_a, ia.imem_we); end
    endtask

    task automatic test_back_to_back();
        op_e         ops [5] = '{OpSub, OpLw, OpSw, OpOr, OpAnd};
        logic [4:0]  rds [5] = '{5'd5, 5'd4, 5'd9, 5'd1, 5'd10};
        logic [4:0]  r1s [5] = '{5'd6, 5'd2, 5'd1, 5'd2, 5'd11};
        logic [4:0]  r2s [5] = '{5'd7, 5'd0, 5'd5, 5'd3, 5'd12};
        logic [12:0] ims [5] = '{13'd0, 13'd8, 13'd12, 13'd0, 13'd0};
        logic [31:0] exp [5] = '{32'h407302B3, 32'h00812203, 32'h0050A623,
                                 32'h003160B3, 32'h00C5F533};
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_a(ops[i], rds[i], r1s[i], r2s[i], ims[i]);
            @(negedge clk);
            n_checks++; if (ia.imem_we !== 1'b1 || ia.imem_addr !== 6'(i)) begin n_fail++; $display("FAIL b2b_write[%0d]: we=%0b addr=%0d want 1 %0d", i, ia.imem_we, ia.imem_addr, i); end
            n_checks++; if (ia.imem_wdata !== exp[i]) begin n_fail++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, ia.imem_wdata, exp[i]); end
            n_checks++; if (words_a !== 7'(i + 1)) begin n_fail++; $display("FAIL b2b_words[%0d]: got %0d want %0d", i, words_a, i + 1); end
        end
        ia.req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (ia.imem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_we: got %0b want 0", ia.imem_we); end
    endtask

    task automatic test_beq_illegal();
        drive_a(OpBeq, 5'd0, 5'd1, 5'd2, 13'h1FF8);
        @(negedge clk);
        n_checks++; if (ia.imem_we !== 1'b1 || ia.imem_addr !== 6'd5) begin n_fail++; $display("FAIL beq_write: we=%0b addr=%0d want 1 5", ia.imem_we, ia.imem_addr); end
        n_checks++; if (ia.imem_wdata !== 32'hFE208CE3) begin n_fail++; $display("FAIL beq_wdata: got %h want fe208ce3", ia.imem_wdata); end
        drive_a(OpBeq, 5'd0, 5'd1, 5'd2, 13'd3);
        @(negedge clk);
        n_checks++; if (ia.imem_we !== 1'b0 || ill_a !== 1'b1) begin n_fail++; $display("FAIL beq_odd: we=%0b illegal=%0b want 0 1", ia.imem_we, ill_a); end
        n_checks++; if (err_a !== 8'd1 || words_a !== 7'd6) begin n_fail++; $display("FAIL beq_odd_cnt: err=%0d words=%0d want 1 6", err_a, words_a); end
        drive_a(OpRsvd, 5'd1, 5'd1, 5'd1, 13'd0);
        @(negedge clk);
        n_checks++; if (ia.imem_we !== 1'b0 || ill_a !== 1'b1 || err_a !== 8'd2) begin n_fail++; $display("FAIL rsvd: we=%0b illegal=%0b err=%0d want 0 1 2", ia.imem_we, ill_a, err_a); end
        drive_a(OpAdd, 5'd3, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        ia.req_valid = 1'b0;
        n_checks++; if (ia.imem_we !== 1'b1 || ia.imem_addr !== 6'd6 || ill_a !== 1'b0) begin n_fail++; $display("FAIL after_ill: we=%0b addr=%0d illegal=%0b want 1 6 0", ia.imem_we, ia.imem_addr, ill_a); end
        n_checks++; if (ia.imem_wdata !== 32'h002081B3) begin n_fail++; $display("FAIL after_ill_wdata: got %h want 002081b3", ia.imem_wdata); end
    endtask

    task automatic test_finish_same_cycle();
        drive_a(OpOr, 5'd1, 5'd2, 5'd3, 13'd0);
        finish_a = 1'b1;
        @(negedge clk);
        ia.req_valid = 1'b0;
        finish_a     = 1'b0;
        n_checks++; if (ia.imem_we !== 1'b1 || ia.imem_addr !== 6'd7) begin n_fail++; $display("FAIL fin_write: we=%0b addr=%0d want 1 7", ia.imem_we, ia.imem_addr); end
        n_checks++; if (ia.imem_wdata !== 32'h003160B3) begin n_fail++; $display("FAIL fin_wdata: got %h want 003160b3", ia.imem_wdata); end
        n_checks++; if (done_a !== 1'b1 || ia.req_ready !== 1'b0 || words_a !== 7'd8) begin n_fail++; $display("FAIL fin_done: done=%0b ready=%0b words=%0d want 1 0 8", done_a, ia.req_ready, words_a); end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n_checks++; if (words_a !== 7'd0 || err_a !== 8'd0) begin n_fail++; $display("FAIL restart_clr: words=%0d err=%0d want 0 0", words_a, err_a); end
        n_checks++; if (ia.req_ready !== 1'b1 || done_a !== 1'b0) begin n_fail++; $display("FAIL restart_state: ready=%0b done=%0b want 1 0", ia.req_ready, done_a); end
        drive_a(OpAnd, 5'd10, 5'd11, 5'd12, 13'd0);
        @(negedge clk);
        ia.req_valid = 1'b0;
        n_checks++; if (ia.imem_we !== 1'b1 || ia.imem_addr !== 6'd0 || ia.imem_wdata !== 32'h00C5F533) begin n_fail++; $display("FAIL restart_write: we=%0b addr=%0d wdata=%h want 1 0 00c5f533", ia.imem_we, ia.imem_addr, ia.imem_wdata); end
    endtask

    task automatic test_reset_mid();
        drive_a(OpAdd, 5'd3, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        ia.req_valid = 1'b0;
        n_checks++; if (ia.imem_we !== 1'b1 || ia.imem_addr !== 6'd1) begin n_fail++; $display("FAIL mid_pre: we=%0b addr=%0d want 1 1", ia.imem_we, ia.imem_addr); end
        rst = 1'b1;
        #1;
        n_checks++; if (ia.imem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we_async: got %0b want 0", ia.imem_we); end
        n_checks++; if (ia.imem_addr !== 6'd0 || ia.imem_wdata !== 32'h0) begin n_fail++; $display("FAIL mid_bus: addr=%0d wdata=%h want 0 0", ia.imem_addr, ia.imem_wdata); end
        n_checks++; if (words_a !== 7'd0 || ia.req_ready !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL mid_state: words=%0d ready=%0b done=%0b want 0 0 0", words_a, ia.req_ready, done_a); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (ia.req_ready !== 1'b0 || ia.imem_we !== 1'b0) begin n_fail++; $display("FAIL mid_post: ready=%0b we=%0b want 0 0", ia.req_ready, ia.imem_we); end
    endtask

    task automatic test_fill();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        ib.req_valid = 1'b1;
        ib.req_op    = OpAdd;
        ib.req_rs1   = 5'd1;
        ib.req_rs2   = 5'd2;
        ib.req_imm   = 13'd0;
        for (int k = 1; k <= 4; k++) begin
            ib.req_rd = 5'(k);
            @(negedge clk);
            n_checks++; if (ib.imem_we !== 1'b1 || ib.imem_addr !== 2'(k - 1)) begin n_fail++; $display("FAIL fill_write[%0d]: we=%0b addr=%0d want 1 %0d", k, ib.imem_we, ib.imem_addr, k - 1); end
            n_checks++; if (ib.imem_wdata !== (32'h00208033 | (32'(k) << 7))) begin n_fail++; $display("FAIL fill_wdata[%0d]: got %h", k, ib.imem_wdata); end
            n_checks++; if (ib.req_ready !== (k < 4) || done_b !== (k == 4) || words_b !== 3'(k)) begin n_fail++; $display("FAIL fill_state[%0d]: ready=%0b done=%0b words=%0d", k, ib.req_ready, done_b, words_b); end
        end
        ib.req_rd = 5'd5;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (ib.imem_we !== 1'b0 || ib.req_ready !== 1'b0 || words_b !== 3'd4 || done_b !== 1'b1) begin n_fail++; $display("FAIL fill_hold: we=%0b ready=%0b words=%0d done=%0b want 0 0 4 1", ib.imem_we, ib.req_ready, words_b, done_b); end
        end
        ib.req_valid = 1'b0;
    endtask

    initial begin
        ia.req_valid = 1'b0; ia.req_op = OpAdd; ia.req_rd = '0; ia.req_rs1 = '0;
        ia.req_rs2 = '0; ia.req_imm = '0;
        ib.req_valid = 1'b0; ib.req_op = OpAdd; ib.req_rd = '0; ib.req_rs1 = '0;
        ib.req_rs2 = '0; ib.req_imm = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_beq_illegal();
        test_finish_same_cycle();
        test_reset_mid();
        test_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and program loader: accepts symbolic operation requests over a valid/ready handshake, packs them into 32-bit instruction words, and writes them to consecutive words of the pipeline's instruction memory. It is the inverse of the pipeline's instruction decode: every word it emits decodes back to the requested operation. It is used to load test programs into instruction memory before the pipeline is released from reset.

## Interface
- DEPTH, 64: instruction memory size in words; ADDR_W = $clog2(DEPTH).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a load session from word 0.
- finish  in  1  pulse; ends the session early.
- req_valid  in  1  request present.
- req_ready  out  1  encoder accepts a request this cycle.
- req_op  in  3  0 ADD, 1 SUB, 2 OR, 3 AND, 4 LW, 5 SW, 6 BEQ, 7 reserved (illegal).
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_imm  in  13  signed immediate. LW/SW use [11:0]. BEQ uses the full byte offset, and [0] must be 0.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- words  out  ADDR_W+1  words written this session.
- done  out  1  high while in DONE.
- illegal  out  1  one-cycle pulse for each rejected request.
- err_count  out  8  rejected requests this session; saturates at 255.

## Operation
- FSM states and transitions:
  - IDLE: on start, go to LOAD.
  - LOAD: on finish or when words reaches DEPTH, go to DONE.
  - DONE: on start, go back to LOAD.
- Entering LOAD clears the write pointer, words and err_count.
- req_ready = (state == LOAD) && (ptr != DEPTH). It is combinational from registered state only and never depends on req_valid.
- A request is accepted on a cycle where req_valid && req_ready.
- On a legal accept: the word is registered, ptr increments, and the write is emitted on the next cycle.
- Illegal requests: op 7, or BEQ with imm[0]=1.
  - The handshake still completes.
  - No write is issued and ptr does not move.
  - illegal pulses on the next cycle and err_count increments, holding at 255.
- Encoding:
  - R-type: {f7, rs2, rs1, f3, rd, 0110011}. ADD f7=0, f3=000. SUB f7=0100000, f3=000. OR f3=110. AND f3=111.
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
  - Fields that an op does not use are ignored (e.g. rd for SW and BEQ).
- Simultaneous finish and accept: the request is accepted and written, then the FSM goes to DONE.
- start while in LOAD is ignored.
- start and finish in the same cycle in IDLE or DONE: start wins.

## Timing
- Reset values:
  - state IDLE, ptr 0.
  - req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0.
  - words 0, done 0, illegal 0, err_count 0.
- Latency: exactly 1 cycle from accept to imem_we. Throughput: 1 word per cycle.
- words and imem_addr update together with imem_we.
- The DONE transition on filling memory happens on the cycle the last word is accepted, so req_ready is 0 on the following cycle.
- The last write still emits while in DONE, and done rises together with that write.
- Reset asserted mid-session: everything returns to its reset value immediately. An in-flight write is dropped, and imem_we falls asynchronously.

## Structure
- Shared package instr_pkg holds:
  - the op enum (3-bit);
  - opcode constants (7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011);
  - funct3/funct7 constants.
  The decode side imports the same constants so both ends stay consistent.
- Sub-module rv_pack: purely combinational; maps op, registers and imm to {word, legal}. The top level contains the FSM, pointer, output register and counters.

## Test plan
- Reset, start, ADD rd=3 rs1=1 rs2=2 -> next cycle imem_we=1, addr 0, wdata 0x002081B3, words=1.
- Back-to-back requests:
  - SUB 5,6,7 -> 0x407302B3 at addr 0.
  - LW rd=4 rs1=2 imm=8 -> 0x00812203 at addr 1.
  - SW rs2=5 rs1=1 imm=12 -> 0x0050A623 at addr 2.
  - One write per cycle throughout.
- BEQ rs1=1 rs2=2 imm=0x1FF8 (-8) -> 0xFE208CE3. BEQ with imm=3 -> illegal pulse, no write, err_count=1, next word goes to the unchanged address.
- DEPTH=4 with continuous valid requests:
  - 4 writes at addrs 0..3.
  - req_ready low on the cycle after the 4th accept.
  - done=1 and words=4.
  - A 5th request is held and never accepted.
- finish asserted in the same cycle as an accept -> that word is written and done rises. A following start -> LOAD with words=0, err_count=0, next write at addr 0.
- Reset asserted the cycle after an accept -> imem_we drops immediately, all outputs are zero, and req_ready stays 0 until start.
